prog_feeder: RTL and testbench
==============================

Name: prog_feeder

Overview:
- Instruction source directly upstream of the hidden CPU core.
- Receives a short program over a load handshake and stores it in a small register file.
- Replays instructions as the CPU's PC advances. It watches the PC the core exposes on its output bus and drives the 6-bit instruction field (opcode[1:0], reg0[1:0], reg1[1:0]) the core samples every clock.
- Detects a run-off-the-end PC and halts the stream with a fixed filler instruction.

Parameters:
- DEPTH, 16, number of instruction slots; power of two, 2..64.
- INSTR_W, 6, instruction width: opcode, reg0 addr, reg1 addr, MSB first.
- PC_W, 8, width of the observed PC.
- FILL_INSTR, 6'b000000, instruction emitted when not in RUN or after halt.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- load_valid  in  1  load_data carries a program word
- load_data  in  INSTR_W  program word to store
- load_ready  out  1  feeder accepts a word this cycle
- run  in  1  request start of replay, or hold in RUN
- pc_in  in  PC_W  PC value from the core
- pc_valid  in  1  pc_in is a PC, not r3, this cycle
- instr_out  out  INSTR_W  instruction to the core
- instr_valid  out  1  instr_out is a real program word
- halted  out  1  replay stopped on out-of-range PC
- count  out  log2(DEPTH)+1  number of words loaded

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high. Reset takes priority over every other input.
- Reset values: state=LOAD, wr_ptr=0, count=0, instr_out=FILL_INSTR, instr_valid=0, halted=0. load_ready=1 from the first cycle after reset. Memory contents are not cleared; count=0 makes them unreachable.
- States: LOAD, RUN, HALT (2-bit encoding).
- LOAD:
  - load_ready = (count < DEPTH).
  - On load_valid & load_ready: mem[wr_ptr] <= load_data, wr_ptr++, count++.
  - When count==DEPTH, load_ready=0 and load_valid is ignored with no overwrite and no wrap.
  - If run=1 and count>0 (count taken after any same-cycle write), go to RUN next cycle. A word accepted in the same cycle is stored and counted.
  - run with count==0 is ignored and the block stays in LOAD.
- RUN:
  - load_ready=0.
  - Each cycle with pc_valid=1 and pc_in < count: instr_out <= mem[pc_in[log2(DEPTH)-1:0]], instr_valid <= 1.
  - Latency is exactly 1 clock from pc_in to instr_out.
  - pc_valid=1 and pc_in >= count: go to HALT, instr_out <= FILL_INSTR, instr_valid <= 0, halted <= 1.
  - pc_valid=0 (core showing r3): instr_out and instr_valid hold their previous values.
  - run=0: return to LOAD, count and wr_ptr clear to 0, instr_out <= FILL_INSTR, instr_valid <= 0.
- HALT:
  - halted=1, instr_out=FILL_INSTR, instr_valid=0; pc_in is ignored.
  - run=0: go to LOAD with count and wr_ptr cleared and halted <= 0.
  - run=1 holds HALT.
- PC comparison uses the full PC_W-bit pc_in, unsigned. A PC that wraps past 255 back into range cannot occur because HALT is sticky.
- Reset mid-load or mid-run: the next cycle is the reset state. There are no partial writes after the rst cycle.

Decomposition:
- Shared package: state encodings (ST_LOAD=2'd0, ST_RUN=2'd1, ST_HALT=2'd2), the FILL_INSTR default, and instruction field offsets (OP_HI=5, R0_HI=3, R1_HI=1).
- One sub-module, prog_mem: DEPTH x INSTR_W register array with one synchronous write port and one combinational read port. The feeder registers the read data itself.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> load_ready=1, count=0, instr_out=6'b000000, instr_valid=0, halted=0.
- Load then replay: load 3 words 6'h11,6'h22,6'h33, assert run, drive pc_in=0,1,2 with pc_valid=1 -> instr_out 6'h11,6'h22,6'h33 one cycle after each PC, instr_valid=1.
- Full buffer: load 17 words with load_valid held -> load_ready drops after the 16th acceptance, count=16, mem[0] still holds the first word.
- Out-of-range PC: after 3 loaded words, pc_in=3 -> next cycle halted=1, instr_valid=0, instr_out=6'b000000; pc_in=0 afterwards stays halted; run=0 -> LOAD, count=0, halted=0.
- Same-cycle load and run, plus pc_valid gap: load_valid=1 with 6'h2A and run=1 in the same cycle at count=0 -> count=1 and state RUN; then pc_valid=0 -> instr_out held.
- Reset mid-run: rst=1 while in RUN with instr_valid=1 -> next cycle state LOAD, instr_valid=0, count=0.

Source files
------------

// File: rtl/prog_feeder_pkg.sv
// ---------------------------------------------------------------------------
// prog_feeder_pkg
// Shared definitions for the program feeder: FSM state encodings, the
// default filler instruction, instruction field offsets and small helpers
// for packing/unpacking the 6-bit instruction word.
//
// Instruction layout (MSB first): opcode[1:0], reg0[1:0], reg1[1:0].
// ---------------------------------------------------------------------------
package prog_feeder_pkg;

  // FSM state encodings (2-bit)
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Instruction emitted whenever no real program word is being driven
  localparam logic [5:0] FILL_INSTR_DEFAULT = 6'b000000;

  // Upper bit of each 2-bit instruction field
  localparam int OP_HI = 5;
  localparam int R0_HI = 3;
  localparam int R1_HI = 1;

  // Structured view of one instruction word
  typedef struct packed {
    logic [1:0] opcode;
    logic [1:0] reg0;
    logic [1:0] reg1;
  } instr_t;

  // Pack the three fields into a flat instruction word
  function automatic logic [5:0] make_instr(input logic [1:0] opcode,
                                            input logic [1:0] reg0,
                                            input logic [1:0] reg1);
    logic [5:0] w;
    w = '0;
    w[OP_HI -: 2] = opcode;
    w[R0_HI -: 2] = reg0;
    w[R1_HI -: 2] = reg1;
    return w;
  endfunction

  // Field extractors
  function automatic logic [1:0] instr_opcode(input logic [5:0] w);
    return w[OP_HI -: 2];
  endfunction

  function automatic logic [1:0] instr_reg0(input logic [5:0] w);
    return w[R0_HI -: 2];
  endfunction

  function automatic logic [1:0] instr_reg1(input logic [5:0] w);
    return w[R1_HI -: 2];
  endfunction

endpackage : prog_feeder_pkg

// File: rtl/prog_feeder_mem.sv
// ---------------------------------------------------------------------------
// prog_mem
// DEPTH x INSTR_W register array holding the loaded program.
// One synchronous write port and one combinational read port; the caller
// registers the read data. Contents are intentionally not reset.
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data at raddr
// ---------------------------------------------------------------------------
module prog_mem
  import prog_feeder_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 6,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : prog_mem

// File: rtl/prog_feeder.sv
// ---------------------------------------------------------------------------
// prog_feeder
// Instruction source feeding the CPU core. A short program is loaded over a
// valid/ready handshake into a small register file, then replayed as the
// core's PC advances. A PC at or beyond the number of loaded words halts the
// stream with a filler instruction until run is dropped.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   load_valid   in   load_data carries a program word
//   load_data    in   program word to store
//   load_ready   out  feeder accepts a word this cycle
//   run          in   request start of replay / hold in RUN
//   pc_in        in   PC observed on the core's output bus
//   pc_valid     in   pc_in carries a PC this cycle (not r3)
//   instr_out    out  instruction to the core (1-cycle latency from pc_in)
//   instr_valid  out  instr_out is a real program word
//   halted       out  replay stopped on an out-of-range PC
//   count        out  number of words loaded
// ---------------------------------------------------------------------------
module prog_feeder
  import prog_feeder_pkg::*;
#(
  parameter int                 DEPTH      = 16,
  parameter int                 INSTR_W    = 6,
  parameter int                 PC_W       = 8,
  parameter logic [INSTR_W-1:0] FILL_INSTR = FILL_INSTR_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [INSTR_W-1:0]         load_data,
  output logic                       load_ready,
  input  logic                       run,
  input  logic [PC_W-1:0]            pc_in,
  input  logic                       pc_valid,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       instr_valid,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  // Common width for the unsigned PC-vs-count comparison
  localparam int CMP_W = (PC_W > CW) ? PC_W : CW;

  logic [1:0]         state;
  logic [AW-1:0]      wr_ptr;
  logic               accept;
  logic               mem_we;
  logic [CW-1:0]      count_next;
  logic               pc_in_range;
  logic [INSTR_W-1:0] mem_rdata;

  // Handshake: only LOAD accepts words, and never beyond a full buffer,
  // so a full buffer neither wraps nor overwrites slot 0.
  assign load_ready = (state == ST_LOAD) && (count < CW'(DEPTH));
  assign accept     = load_valid && load_ready;

  // Reset wins over a same-cycle write so no word lands during rst.
  assign mem_we     = accept && !rst;

  // Count as it will be after this cycle's write; used for the run
  // decision so a word accepted alongside run is counted.
  assign count_next = count + CW'(accept);

  // Full-width unsigned compare so large PCs never alias into range.
  assign pc_in_range = CMP_W'(pc_in) < CMP_W'(count);

  prog_mem #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (load_data),
    .raddr (pc_in[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Main FSM. Dropping run takes priority over PC handling in RUN so the
  // feeder always returns cleanly to LOAD. HALT is sticky until run falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      wr_ptr      <= '0;
      count       <= '0;
      instr_out   <= FILL_INSTR;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count_next;
          end
          if (run && (count_next != '0)) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!run) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            count       <= '0;
            instr_out   <= FILL_INSTR;
            instr_valid <= 1'b0;
          end else if (pc_valid) begin
            if (pc_in_range) begin
              instr_out   <= mem_rdata;
              instr_valid <= 1'b1;
            end else begin
              state       <= ST_HALT;
              instr_out   <= FILL_INSTR;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end
          end
        end

        ST_HALT: begin
          instr_out   <= FILL_INSTR;
          instr_valid <= 1'b0;
          if (!run) begin
            state  <= ST_LOAD;
            wr_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
          end
        end

        default: begin
          state       <= ST_LOAD;
          wr_ptr      <= '0;
          count       <= '0;
          instr_out   <= FILL_INSTR;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule : prog_feeder

// File: tb/tb_prog_feeder.sv
// ---------------------------------------------------------------------------
// tb_prog_feeder
// Self-checking bench for prog_feeder: a table of per-cycle vectors with
// hand-computed expected outputs, plus a hand-written full-buffer sequence.
// ---------------------------------------------------------------------------
module tb_prog_feeder;
  import prog_feeder_pkg::*;

  localparam int DEPTH   = 16;
  localparam int INSTR_W = 6;
  localparam int PC_W    = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk;
  logic               rst;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               run;
  logic [PC_W-1:0]    pc_in;
  logic               pc_valid;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               halted;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;

  prog_feeder #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .run         (run),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .halted      (halted),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected 1 ns after the edge
  typedef struct {
    string              name;
    logic               rst;
    logic               lv;
    logic [INSTR_W-1:0] ld;
    logic               run;
    logic [PC_W-1:0]    pc;
    logic               pv;
    logic               exp_lr;
    logic [INSTR_W-1:0] exp_io;
    logic               exp_iv;
    logic               exp_h;
    logic [CW-1:0]      exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive inputs right after an edge, then sample 1 ns after the next edge
  task automatic apply_stimulus(input logic r, input logic lv,
                                input logic [INSTR_W-1:0] ld, input logic rn,
                                input logic [PC_W-1:0] pc, input logic pv);
    rst        = r;
    load_valid = lv;
    load_data  = ld;
    run        = rn;
    pc_in      = pc;
    pc_valid   = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic r, input logic lv,
                         input logic [INSTR_W-1:0] ld, input logic rn,
                         input logic [PC_W-1:0] pc, input logic pv,
                         input logic lr, input logic [INSTR_W-1:0] io,
                         input logic iv, input logic h, input logic [CW-1:0] cnt);
    vec_t v;
    v.name = name; v.rst = r; v.lv = lv; v.ld = ld; v.run = rn; v.pc = pc;
    v.pv = pv; v.exp_lr = lr; v.exp_io = io; v.exp_iv = iv; v.exp_h = h;
    v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  function automatic logic [INSTR_W-1:0] word_of(input int i);
    return INSTR_W'(i * 5 + 7);
  endfunction

  initial begin
    logic [INSTR_W-1:0] w2a;
    w2a = make_instr(2'd2, 2'd2, 2'd2);

    rst = 1'b1; load_valid = 1'b0; load_data = '0; run = 1'b0;
    pc_in = '0; pc_valid = 1'b0;

    //       name            rst lv  ld     run pc    pv   lr  io     iv  h   cnt
    add_vec("rst_with_load",  1,  1, 6'h3F,  0, 8'd0, 0,   1, 6'h00,  0,  0,  0);
    add_vec("rst_hold",       1,  0, 6'h00,  0, 8'd0, 0,   1, 6'h00,  0,  0,  0);
    add_vec("run_empty",      0,  0, 6'h00,  1, 8'd0, 0,   1, 6'h00,  0,  0,  0);
    add_vec("load_11",        0,  1, 6'h11,  0, 8'd0, 0,   1, 6'h00,  0,  0,  1);
    add_vec("load_22",        0,  1, 6'h22,  0, 8'd0, 0,   1, 6'h00,  0,  0,  2);
    add_vec("load_33",        0,  1, 6'h33,  0, 8'd0, 0,   1, 6'h00,  0,  0,  3);
    add_vec("enter_run",      0,  0, 6'h00,  1, 8'd0, 0,   0, 6'h00,  0,  0,  3);
    add_vec("pc0",            0,  0, 6'h00,  1, 8'd0, 1,   0, 6'h11,  1,  0,  3);
    add_vec("pc1",            0,  0, 6'h00,  1, 8'd1, 1,   0, 6'h22,  1,  0,  3);
    add_vec("pc2",            0,  0, 6'h00,  1, 8'd2, 1,   0, 6'h33,  1,  0,  3);
    add_vec("pc_gap",         0,  0, 6'h00,  1, 8'd3, 0,   0, 6'h33,  1,  0,  3);
    add_vec("pc3_halt",       0,  0, 6'h00,  1, 8'd3, 1,   0, 6'h00,  0,  1,  3);
    add_vec("halt_sticky",    0,  0, 6'h00,  1, 8'd0, 1,   0, 6'h00,  0,  1,  3);
    add_vec("halt_to_load",   0,  0, 6'h00,  0, 8'd0, 0,   1, 6'h00,  0,  0,  0);
    add_vec("load_and_run",   0,  1, w2a,    1, 8'd0, 0,   0, 6'h00,  0,  0,  1);
    add_vec("gap_fill",       0,  0, 6'h00,  1, 8'd0, 0,   0, 6'h00,  0,  0,  1);
    add_vec("pc0_2a",         0,  0, 6'h00,  1, 8'd0, 1,   0, 6'h2A,  1,  0,  1);
    add_vec("gap_hold_2a",    0,  0, 6'h00,  1, 8'd0, 0,   0, 6'h2A,  1,  0,  1);
    add_vec("rst_mid_run",    1,  0, 6'h00,  1, 8'd0, 1,   1, 6'h00,  0,  0,  0);
    add_vec("post_rst_idle",  0,  0, 6'h00,  0, 8'd0, 0,   1, 6'h00,  0,  0,  0);
    add_vec("load_05",        0,  1, 6'h05,  0, 8'd0, 0,   1, 6'h00,  0,  0,  1);
    add_vec("run_05",         0,  0, 6'h00,  1, 8'd0, 0,   0, 6'h00,  0,  0,  1);
    add_vec("pc0_05",         0,  0, 6'h00,  1, 8'd0, 1,   0, 6'h05,  1,  0,  1);
    add_vec("run_drop",       0,  0, 6'h00,  0, 8'd0, 1,   1, 6'h00,  0,  0,  0);
    add_vec("pc_big_load",    0,  0, 6'h00,  0, 8'd200, 1, 1, 6'h00,  0,  0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].lv, vecs[i].ld, vecs[i].run,
                     vecs[i].pc, vecs[i].pv);
      check_output({vecs[i].name, ".load_ready"},  32'(load_ready),  32'(vecs[i].exp_lr));
      check_output({vecs[i].name, ".instr_out"},   32'(instr_out),   32'(vecs[i].exp_io));
      check_output({vecs[i].name, ".instr_valid"}, 32'(instr_valid), 32'(vecs[i].exp_iv));
      check_output({vecs[i].name, ".halted"},      32'(halted),      32'(vecs[i].exp_h));
      check_output({vecs[i].name, ".count"},       32'(count),       32'(vecs[i].exp_cnt));
    end

    // Full buffer: 17 words offered back to back, the last one must be refused
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      check_output($sformatf("full.lr_before_%0d", i), 32'(load_ready),
                   32'(i < DEPTH));
      apply_stimulus(1'b0, 1'b1, word_of(i), 1'b0, '0, 1'b0);
      check_output($sformatf("full.count_%0d", i), 32'(count),
                   32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
    end
    check_output("full.lr_after", 32'(load_ready), 32'(0));
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, '0, 1'b0);
    check_output("full.enter_run", 32'(load_ready), 32'(0));
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'd0, 1'b1);
    check_output("full.mem0", 32'(instr_out), 32'(word_of(0)));
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'd15, 1'b1);
    check_output("full.mem15", 32'(instr_out), 32'(word_of(15)));
    check_output("full.mem15_valid", 32'(instr_valid), 32'(1));
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 8'd16, 1'b1);
    check_output("full.pc16_halt", 32'(halted), 32'(1));
    check_output("full.pc16_fill", 32'(instr_out), 32'(0));
    check_output("full.pc16_valid", 32'(instr_valid), 32'(0));
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    check_output("full.back_count", 32'(count), 32'(0));
    check_output("full.back_halted", 32'(halted), 32'(0));

    // Field helpers agree with the packed layout
    check_output("pkg.opcode", 32'(instr_opcode(word_of(3))), 32'(word_of(3) >> 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_prog_feeder
